// File: rtl/iu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select
// encodings, FSM state encodings, IR field positions and the PC step.
package iu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 8;

  // Next-PC mux select encodings
  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_J   = 2'b10;
  localparam logic [1:0] PC_SEL_JR  = 2'b11;

  typedef enum logic [1:0] {
    IU_IDLE = 2'b00,
    IU_REQ  = 2'b01,
    IU_DONE = 2'b10
  } iu_state_e;

  // IR field positions (MIPS-style layout)
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JIDX_W  = 26;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/iu_next_pc.sv
// Combinational next-PC mux.
//   pc_i      current (already incremented) PC
//   se_imm_i  sign-extended immediate from IR
//   jidx_i    26-bit jump index from IR
//   rs_i      register value for jr/jalr
//   pc_sel_i  00 PC+4, 01 branch, 10 jump, 11 rs
//   next_pc_o selected next PC
module iu_next_pc
  import iu_pkg::*;
(
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   se_imm_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic [XLEN-1:0]   rs_i,
  input  logic [1:0]        pc_sel_i,
  output logic [XLEN-1:0]   next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    case (pc_sel_i)
      PC_SEL_INC: next_pc_o = pc_i + PC_STEP;
      PC_SEL_BR:  next_pc_o = pc_i + (se_imm_i << 2);
      PC_SEL_J:   next_pc_o = {pc_i[XLEN-1:XLEN-4], jidx_i, 2'b00};
      PC_SEL_JR:  next_pc_o = rs_i;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds PC and IR, fetches over a req/ack memory
// handshake and decodes IR fields for the datapath.
// Optional feature macro: IU_TIMEOUT_EN (abort a fetch after TIMEOUT_CYCLES
// request cycles without ack).
// Ports:
//   clk, reset (async, active-high)
//   fetch_start, pc_ld, pc_sel[1:0], rs_in[31:0]   control/next-PC inputs
//   imem_rdata[31:0], imem_ack / imem_rd, imem_addr[31:0]   memory handshake
//   busy, ir_valid, fetch_err                       status
//   pc_out, ir_out, se_imm, s_addr, t_addr, d_addr, shamt, opcode, funct   decode
module instruction_fetch_unit
  import iu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC       = 32'h0000_0000,
  parameter int unsigned  TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_ld,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] rs_in,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  output logic        busy,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic [31:0] se_imm,
  output logic [4:0]  s_addr,
  output logic [4:0]  t_addr,
  output logic [4:0]  d_addr,
  output logic [4:0]  shamt,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  iu_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   next_pc;

`ifdef IU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  iu_next_pc u_next_pc (
    .pc_i      (pc_q),
    .se_imm_i  (se_imm),
    .jidx_i    (ir_q[JIDX_W-1:0]),
    .rs_i      (rs_in),
    .pc_sel_i  (pc_sel),
    .next_pc_o (next_pc)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IU_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
`ifdef IU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
`ifdef IU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state, PC/IR update and error pulse
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = 1'b0;
`ifdef IU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IU_IDLE: begin
        if (pc_ld) pc_d = next_pc;
        // Alignment is judged on the PC the fetch will actually use
        if (fetch_start) begin
          if (pc_d[1:0] == 2'b00) begin
            state_d = IU_REQ;
`ifdef IU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      IU_REQ: begin
        // Ack beats a simultaneous timeout
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_STEP;
          state_d = IU_DONE;
        end
`ifdef IU_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = IU_IDLE;
          err_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      IU_DONE: state_d = IU_IDLE;
      default: state_d = IU_IDLE;
    endcase
  end

  // Status and memory outputs decode directly from registered state
  assign imem_rd   = (state_q == IU_REQ);
  assign imem_addr = pc_q;
  assign busy      = (state_q != IU_IDLE);
  assign ir_valid  = (state_q == IU_DONE);
  assign fetch_err = err_q;

  assign pc_out = pc_q;
  assign ir_out = ir_q;
  assign se_imm = {{(XLEN-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign opcode = ir_q[OPC_LSB +: OPC_W];
  assign s_addr = ir_q[RS_LSB  +: REG_W];
  assign t_addr = ir_q[RT_LSB  +: REG_W];
  assign d_addr = ir_q[RD_LSB  +: REG_W];
  assign shamt  = ir_q[SH_LSB  +: REG_W];
  assign funct  = ir_q[FN_LSB  +: FN_W];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes the expected
// result of each fetch attempt; a monitor pops on ir_valid/fetch_err.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, pc_ld, imem_ack;
  logic [1:0]  pc_sel;
  logic [31:0] rs_in, imem_rdata;
  logic        imem_rd, busy, ir_valid, fetch_err;
  logic [31:0] imem_addr, pc_out, ir_out, se_imm;
  logic [4:0]  s_addr, t_addr, d_addr, shamt;
  logic [5:0]  opcode, funct;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] se;
    logic [4:0]  s, t, d, sh;
    logic [5:0]  op, fn;
  } exp_t;

  exp_t sb[$];

  instruction_fetch_unit #(
    .RESET_PC       (32'h0000_0400),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_ld       (pc_ld),
    .pc_sel      (pc_sel),
    .rs_in       (rs_in),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .busy        (busy),
    .ir_valid    (ir_valid),
    .fetch_err   (fetch_err),
    .pc_out      (pc_out),
    .ir_out      (ir_out),
    .se_imm      (se_imm),
    .s_addr      (s_addr),
    .t_addr      (t_addr),
    .d_addr      (d_addr),
    .shamt       (shamt),
    .opcode      (opcode),
    .funct       (funct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t fetch_rec(input logic [31:0] pc, input logic [31:0] ir);
    exp_t e;
    e.is_err = 1'b0;
    e.pc = pc;
    e.ir = ir;
    e.se = 32'h0; e.s = 5'h0; e.t = 5'h0; e.d = 5'h0; e.sh = 5'h0; e.op = 6'h0; e.fn = 6'h0;
    return e;
  endfunction

  // Monitor: compare every DUT completion against the oldest expectation
  always @(negedge clk) begin
    if (!reset && (ir_valid || fetch_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: ir_valid=%0b fetch_err=%0b with empty scoreboard at %0t",
                 ir_valid, fetch_err, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_fetch_err", 32'(fetch_err), 32'(e.is_err));
        chk("mon_ir_valid",  32'(ir_valid),  32'(!e.is_err));
        chk("mon_pc_out",    pc_out, e.pc);
        chk("mon_ir_out",    ir_out, e.ir);
        if (!e.is_err) begin
          chk("mon_se_imm", se_imm, e.se);
          chk("mon_s_addr", 32'(s_addr), 32'(e.s));
          chk("mon_t_addr", 32'(t_addr), 32'(e.t));
          chk("mon_d_addr", 32'(d_addr), 32'(e.d));
          chk("mon_shamt",  32'(shamt),  32'(e.sh));
          chk("mon_opcode", 32'(opcode), 32'(e.op));
          chk("mon_funct",  32'(funct),  32'(e.fn));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1; fetch_start = 1'b0; pc_ld = 1'b0; imem_ack = 1'b0;
    pc_sel = 2'b00; rs_in = '0; imem_rdata = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_pc_out",  pc_out, 32'h0000_0400);
    chk("rst_ir_out",  ir_out, 32'h0);
    chk("rst_imem_rd", 32'(imem_rd), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // Fetch at 0x400, ack after 3 extra REQ cycles
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("req_imem_rd",   32'(imem_rd), 32'h1);
    chk("req_imem_addr", imem_addr, 32'h0000_0400);
    chk("req_busy",      32'(busy), 32'h1);
    repeat (3) tick();
    e = fetch_rec(32'h0000_0404, 32'h8C22_FFFC);
    e.se = 32'hFFFF_FFFC; e.op = 6'h23; e.s = 5'd1; e.t = 5'd2; e.d = 5'h1F; e.sh = 5'h1F; e.fn = 6'h3C;
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_FFFC;
    tick();
    imem_ack = 1'b0;
    chk("done_ir_valid", 32'(ir_valid), 32'h1);
    tick();
    chk("post_ir_valid", 32'(ir_valid), 32'h0);
    chk("post_busy",     32'(busy), 32'h0);

    // Branch target from incremented PC: 0x404 + (-4 << 2)
    pc_sel = 2'b01; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("branch_pc", pc_out, 32'h0000_03F4);

    // Fetch a jump instruction, then take the jump
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    e = fetch_rec(32'h0000_03F8, 32'h0810_0000);
    e.op = 6'h02; e.t = 5'h10;
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = 32'h0810_0000;
    tick();
    imem_ack = 1'b0;
    tick();
    pc_sel = 2'b10; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("jump_pc", pc_out, 32'h0040_0000);

    // Misaligned jr target: fetch refused with an error pulse
    pc_sel = 2'b11; rs_in = 32'h0000_1002; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("jr_pc", pc_out, 32'h0000_1002);
    e = fetch_rec(32'h0000_1002, 32'h0810_0000);
    e.is_err = 1'b1;
    sb.push_back(e);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("misalign_imem_rd", 32'(imem_rd), 32'h0);
    chk("misalign_busy",    32'(busy), 32'h0);
    tick();

    // pc_ld + fetch_start together: fetch uses the new PC; both ignored in REQ
    rs_in = 32'h0000_0800; pc_ld = 1'b1; fetch_start = 1'b1;
    tick();
    pc_ld = 1'b0; fetch_start = 1'b0;
    chk("same_cyc_imem_rd",   32'(imem_rd), 32'h1);
    chk("same_cyc_imem_addr", imem_addr, 32'h0000_0800);
    rs_in = 32'h0000_1234; pc_ld = 1'b1; fetch_start = 1'b1;
    tick();
    pc_ld = 1'b0; fetch_start = 1'b0;
    chk("req_ignore_addr", imem_addr, 32'h0000_0800);
    chk("req_ignore_busy", 32'(busy), 32'h1);
    e = fetch_rec(32'h0000_0804, 32'h00A6_4020);
    e.se = 32'h0000_4020; e.s = 5'd5; e.t = 5'd6; e.d = 5'd8; e.fn = 6'h20;
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = 32'h00A6_4020;
    tick();
    imem_ack = 1'b0;
    tick();

    // Ack outside REQ is ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    imem_ack = 1'b0;
    chk("stray_ack_ir",   ir_out, 32'h00A6_4020);
    chk("stray_ack_busy", 32'(busy), 32'h0);

    // Minimum latency fetch at 0xFFFF_FFFC: PC wraps to 0
    pc_sel = 2'b11; rs_in = 32'hFFFF_FFFC; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    e = fetch_rec(32'h0000_0000, 32'h3C01_8000);
    e.se = 32'hFFFF_8000; e.op = 6'h0F; e.t = 5'd1; e.d = 5'h10;
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = 32'h3C01_8000;
    tick();
    imem_ack = 1'b0;
    chk("min_lat_ir_valid", 32'(ir_valid), 32'h1);
    tick();

`ifdef IU_TIMEOUT_EN
    // No ack: abort after exactly 4 REQ cycles, PC/IR unchanged
    e = fetch_rec(32'h0000_0000, 32'h3C01_8000);
    e.is_err = 1'b1;
    sb.push_back(e);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_imem_rd",    32'(imem_rd), 32'h0);
    tick();
`else
    // No timeout: REQ waits indefinitely for ack
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    repeat (20) tick();
    chk("no_timeout_busy",    32'(busy), 32'h1);
    chk("no_timeout_imem_rd", 32'(imem_rd), 32'h1);
    e = fetch_rec(32'h0000_0004, 32'h8C22_FFFC);
    e.se = 32'hFFFF_FFFC; e.op = 6'h23; e.s = 5'd1; e.t = 5'd2; e.d = 5'h1F; e.sh = 5'h1F; e.fn = 6'h3C;
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_FFFC;
    tick();
    imem_ack = 1'b0;
    tick();
    n = 0;
`endif

    // Reset mid-fetch drops imem_rd immediately
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("pre_rst_imem_rd", 32'(imem_rd), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_imem_rd", 32'(imem_rd), 32'h0);
    chk("mid_rst_busy",    32'(busy), 32'h0);
    chk("mid_rst_pc",      pc_out, 32'h0000_0400);
    chk("mid_rst_ir",      ir_out, 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
